// File: rtl/synt_seq_ctrl.sv
// Synthesizer power-up / calibration sequencer: OFF -> CAL -> SETTLE -> READY, with
// relock on channel change and a CAL watchdog that parks the block in ERROR.
module synt_seq_ctrl #(
    parameter int CNT_W       = 16,
    parameter int TCAL_CYC    = 50,
    parameter int TSET_CYC    = 10,
    parameter int TRELOCK_CYC = 5,
    parameter int TOUT_CYC    = 200,
    parameter int CH_W        = 7
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic            PU_SYNT,
    input  logic            CAL_SYNT,
    input  logic            CH_LOAD,
    input  logic [CH_W-1:0] CH_CODE,
    output logic [CH_W-1:0] CH_ACT,
    output logic            RDY_SYNT,
    output logic            CAL_BUSY,
    output logic            ERR_TOUT,
    output logic [2:0]      STATE
);

    typedef enum logic [2:0] {
        S_OFF    = 3'd0,
        S_CAL    = 3'd1,
        S_SETTLE = 3'd2,
        S_READY  = 3'd3,
        S_RELOCK = 3'd4,
        S_ERROR  = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] TCAL  = CNT_W'(TCAL_CYC);
    localparam logic [CNT_W-1:0] TSET  = CNT_W'(TSET_CYC);
    localparam logic [CNT_W-1:0] TRLK  = CNT_W'(TRELOCK_CYC);
    localparam logic [CNT_W-1:0] TOUT  = CNT_W'(TOUT_CYC);

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [CNT_W-1:0] wd, wd_nx;
    logic             err_nx;
    logic [CH_W-1:0]  ch_nx;

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        wd_nx    = wd;
        err_nx   = ERR_TOUT;
        ch_nx    = CH_ACT;
        if (!PU_SYNT) begin
            state_nx = S_OFF;
            cnt_nx   = '0;
            wd_nx    = '0;
            err_nx   = 1'b0;
        end else begin
            if (CH_LOAD) ch_nx = CH_CODE;
            unique case (state)
                S_OFF: begin
                    state_nx = S_CAL;
                    cnt_nx   = TCAL;
                    wd_nx    = '0;
                end
                S_CAL: begin
                    if (wd != TOUT) wd_nx = wd + ONE;
                    // Calibration completing on the timeout edge still counts as success.
                    if (CAL_SYNT && cnt == ONE) begin
                        state_nx = S_SETTLE;
                        cnt_nx   = TSET;
                    end else begin
                        if (CAL_SYNT && cnt > ONE) cnt_nx = cnt - ONE;
                        if (wd_nx == TOUT) begin
                            state_nx = S_ERROR;
                            err_nx   = 1'b1;
                        end
                    end
                end
                S_SETTLE: begin
                    if (cnt <= ONE) begin
                        state_nx = S_READY;
                        cnt_nx   = '0;
                    end else begin
                        cnt_nx = cnt - ONE;
                    end
                end
                S_READY: begin
                    if (CH_LOAD) begin
                        state_nx = S_RELOCK;
                        cnt_nx   = TRLK;
                    end
                end
                S_RELOCK: begin
                    if (CH_LOAD) begin
                        cnt_nx = TRLK;
                    end else if (cnt <= ONE) begin
                        state_nx = S_READY;
                        cnt_nx   = '0;
                    end else begin
                        cnt_nx = cnt - ONE;
                    end
                end
                S_ERROR: ;
                default: begin
                    state_nx = S_OFF;
                    cnt_nx   = '0;
                    wd_nx    = '0;
                end
            endcase
        end
    end

    // Flags are decoded from the next state so they line up with STATE.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state    <= S_OFF;
            cnt      <= '0;
            wd       <= '0;
            ERR_TOUT <= 1'b0;
            CH_ACT   <= '0;
            RDY_SYNT <= 1'b0;
            CAL_BUSY <= 1'b0;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            wd       <= wd_nx;
            ERR_TOUT <= err_nx;
            CH_ACT   <= ch_nx;
            RDY_SYNT <= (state_nx == S_READY);
            CAL_BUSY <= (state_nx == S_CAL);
        end
    end

    assign STATE = state;

endmodule

// File: tb/tb_synt_seq_ctrl.sv
// Directed bench for synt_seq_ctrl: timestamp-based reference model checked every cycle,
// plus literal checkpoints, and a second instance with all phase lengths set to 1.
module tb_synt_seq_ctrl;
    localparam int TCAL = 50, TSET = 10, TRLK = 5, TOUT = 200;
    localparam int OFF = 0, CAL = 1, SETTLE = 2, READY = 3, RELOCK = 4, ERROR = 5;

    logic       CLK = 1'b0, RST_N = 1'b0;
    logic       PU_SYNT = 1'b0, CAL_SYNT = 1'b0, CH_LOAD = 1'b0;
    logic [6:0] CH_CODE = '0;
    logic [6:0] CH_ACT;
    logic       RDY_SYNT, CAL_BUSY, ERR_TOUT;
    logic [2:0] STATE;

    logic       pu2 = 1'b0, ld2 = 1'b0;
    logic [6:0] ch_act2;
    logic       rdy2, busy2, err2;
    logic [2:0] state2;

    int n_chk = 0, n_fail = 0;

    always #10 CLK = ~CLK;

    synt_seq_ctrl dut (
        .CLK(CLK), .RST_N(RST_N), .PU_SYNT(PU_SYNT), .CAL_SYNT(CAL_SYNT),
        .CH_LOAD(CH_LOAD), .CH_CODE(CH_CODE), .CH_ACT(CH_ACT), .RDY_SYNT(RDY_SYNT),
        .CAL_BUSY(CAL_BUSY), .ERR_TOUT(ERR_TOUT), .STATE(STATE));

    synt_seq_ctrl #(.TCAL_CYC(1), .TSET_CYC(1), .TRELOCK_CYC(1)) dut1 (
        .CLK(CLK), .RST_N(RST_N), .PU_SYNT(pu2), .CAL_SYNT(CAL_SYNT),
        .CH_LOAD(ld2), .CH_CODE(CH_CODE), .CH_ACT(ch_act2), .RDY_SYNT(rdy2),
        .CAL_BUSY(busy2), .ERR_TOUT(err2), .STATE(state2));

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: phase plus timestamps/credit counts rather than down-counters.
    int m_st, m_cyc, cal_credit, cal_age, settle_end, relock_end;
    logic [6:0] m_ch;
    bit m_err;

    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            m_st = OFF; m_cyc = 0; m_ch = '0; m_err = 0;
            cal_credit = 0; cal_age = 0; settle_end = 0; relock_end = 0;
        end else begin
            m_cyc++;
            if (!PU_SYNT) begin
                m_st = OFF; m_err = 0;
            end else begin
                if (CH_LOAD) m_ch = CH_CODE;
                case (m_st)
                    OFF: begin m_st = CAL; cal_credit = 0; cal_age = 0; end
                    CAL: begin
                        cal_age++;
                        if (CAL_SYNT) cal_credit++;
                        if (cal_credit == TCAL) begin m_st = SETTLE; settle_end = m_cyc + TSET; end
                        else if (cal_age >= TOUT) begin m_st = ERROR; m_err = 1; end
                    end
                    SETTLE: if (m_cyc == settle_end) m_st = READY;
                    READY:  if (CH_LOAD) begin m_st = RELOCK; relock_end = m_cyc + TRLK; end
                    RELOCK: begin
                        if (CH_LOAD) relock_end = m_cyc + TRLK;
                        else if (m_cyc == relock_end) m_st = READY;
                    end
                    default: ;
                endcase
            end
        end
    end

    always @(negedge CLK) begin
        chk("state", int'(STATE), m_st);
        chk("rdy", int'(RDY_SYNT), int'(m_st == READY));
        chk("busy", int'(CAL_BUSY), int'(m_st == CAL));
        chk("err", int'(ERR_TOUT), int'(m_err));
        chk("ch_act", int'(CH_ACT), int'(m_ch));
    end

    task automatic step(input int n);
        repeat (n) @(negedge CLK);
    endtask

    initial begin
        step(2);
        chk("rst_state", int'(STATE), OFF);
        chk("rst_rdy", int'(RDY_SYNT), 0);
        chk("rst_ch", int'(CH_ACT), 0);
        RST_N = 1'b1;
        step(1);

        // Nominal power-up; edge 0 is the first edge sampling PU_SYNT=1.
        PU_SYNT = 1; CAL_SYNT = 1;
        step(1);  chk("t1_cal_e0", int'(STATE), CAL); chk("t1_busy_e0", int'(CAL_BUSY), 1);
        step(49); chk("t1_busy_e49", int'(CAL_BUSY), 1);
        step(1);  chk("t1_settle_e50", int'(STATE), SETTLE); chk("t1_busy_e50", int'(CAL_BUSY), 0);
        step(9);  chk("t1_rdy_e59", int'(RDY_SYNT), 0);
        step(1);  chk("t1_rdy_e60", int'(RDY_SYNT), 1); chk("t1_ready_e60", int'(STATE), READY);

        // Relock, then restart of relock by a second load.
        CH_CODE = 7'h2A; CH_LOAD = 1;
        step(1); CH_LOAD = 0;
        chk("rl_ch", int'(CH_ACT), 'h2A); chk("rl_rdy0", int'(RDY_SYNT), 0);
        step(4); chk("rl_rdy4", int'(RDY_SYNT), 0);
        step(1); chk("rl_rdy5", int'(RDY_SYNT), 1);
        CH_LOAD = 1; step(1); CH_LOAD = 0;
        step(2);
        CH_CODE = 7'h15; CH_LOAD = 1; step(1); CH_LOAD = 0;
        chk("rl2_ch", int'(CH_ACT), 'h15); chk("rl2_state", int'(STATE), RELOCK);
        step(4); chk("rl2_rdy4", int'(RDY_SYNT), 0);
        step(1); chk("rl2_rdy5", int'(RDY_SYNT), 1);

        // Seven CAL_SYNT-low cycles stretch latency to edge 67.
        PU_SYNT = 0; step(1); chk("off", int'(STATE), OFF); chk("off_ch_kept", int'(CH_ACT), 'h15);
        PU_SYNT = 1; step(1); step(20);
        CAL_SYNT = 0; step(7); CAL_SYNT = 1;
        step(39); chk("t2_rdy_e66", int'(RDY_SYNT), 0);
        step(1);  chk("t2_rdy_e67", int'(RDY_SYNT), 1); chk("t2_noerr", int'(ERR_TOUT), 0);

        // Watchdog timeout.
        PU_SYNT = 0; step(1);
        PU_SYNT = 1; CAL_SYNT = 0; step(1);
        step(199); chk("t3_cal_e199", int'(STATE), CAL); chk("t3_err_e199", int'(ERR_TOUT), 0);
        step(1);   chk("t3_error_e200", int'(STATE), ERROR); chk("t3_err_e200", int'(ERR_TOUT), 1);
        CH_CODE = 7'h33; CH_LOAD = 1; step(1); CH_LOAD = 0;
        chk("t3_ch_in_err", int'(CH_ACT), 'h33);
        CAL_SYNT = 1; step(5); chk("t3_hold", int'(STATE), ERROR); chk("t3_sticky", int'(ERR_TOUT), 1);
        PU_SYNT = 0; step(1); chk("t3_off", int'(STATE), OFF); chk("t3_err_clr", int'(ERR_TOUT), 0);

        // Power-down mid-CAL, then full sequence again.
        PU_SYNT = 1; step(1); step(30);
        PU_SYNT = 0; step(1); chk("t5_off", int'(STATE), OFF);
        PU_SYNT = 1; step(1); step(59); chk("t5_rdy_e59", int'(RDY_SYNT), 0);
        step(1); chk("t5_rdy_e60", int'(RDY_SYNT), 1);

        // Async reset in SETTLE, between clock edges.
        PU_SYNT = 0; step(1);
        PU_SYNT = 1; step(1); step(55); chk("t5_settle", int'(STATE), SETTLE);
        #5 RST_N = 0;
        #1 chk("arst_state", int'(STATE), OFF); chk("arst_ch", int'(CH_ACT), 0);
        chk("arst_rdy", int'(RDY_SYNT), 0);
        PU_SYNT = 0;
        step(1); RST_N = 1; step(1);

        // Minimum phase lengths on the second instance.
        pu2 = 1; step(1); chk("p1_cal", int'(state2), CAL);
        step(1); chk("p1_settle", int'(state2), SETTLE); chk("p1_rdy_e1", int'(rdy2), 0);
        step(1); chk("p1_rdy_e2", int'(rdy2), 1);
        CH_CODE = 7'h55; ld2 = 1; step(1); ld2 = 0;
        chk("p1_relock", int'(state2), RELOCK); chk("p1_rl_rdy", int'(rdy2), 0);
        chk("p1_ch", int'(ch_act2), 'h55);
        step(1); chk("p1_back", int'(rdy2), 1); chk("p1_ready", int'(state2), READY);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/synt_seq_ctrl.md
Name: synt_seq_ctrl

Overview:
- Parametrised synthesizer power-up and calibration sequencer; successor to the single fixed 60-cycle ready timer.
- Splits power-up into separate calibration and settle phases and adds a short relock phase on channel change.
- Adds a calibration watchdog with a sticky error flag, plus a state readout for the radio control FSM.
- Sits between the radio control FSM and the synthesizer analog block.

Parameters:
CNT_W, 16, width of the phase counter and the watchdog counter
TCAL_CYC, 50, calibration length in CAL_SYNT-enabled cycles (10 us at 5 MHz)
TSET_CYC, 10, settle length in cycles after calibration (2 us at 5 MHz)
TRELOCK_CYC, 5, relock length in cycles after a channel change
TOUT_CYC, 200, watchdog limit in cycles spent in CAL
CH_W, 7, channel code width
Constraints: all T*_CYC >= 1 and < 2^CNT_W; TOUT_CYC > TCAL_CYC.

Ports:
CLK  in  1  system clock (5 MHz)
RST_N  in  1  asynchronous reset, active low
PU_SYNT  in  1  synthesizer power-up; low forces OFF
CAL_SYNT  in  1  calibration enable; CAL counter advances only while high
CH_LOAD  in  1  single-cycle strobe: load CH_CODE
CH_CODE  in  CH_W  requested channel
CH_ACT  out  CH_W  registered active channel
RDY_SYNT  out  1  synthesizer locked and usable (registered)
CAL_BUSY  out  1  high while in CAL
ERR_TOUT  out  1  sticky calibration timeout
STATE  out  3  OFF=0, CAL=1, SETTLE=2, READY=3, RELOCK=4, ERROR=5

Behaviour:
- Reset: asynchronous and active-low. All of the following are 0 / OFF: STATE, counters, RDY_SYNT, CAL_BUSY, ERR_TOUT, CH_ACT.
- Outputs: all registered. RDY_SYNT=1 only in READY; CAL_BUSY=1 only in CAL.
- Priority, highest first: PU_SYNT=0 > ERROR hold > CH_LOAD > counter expiry.
- PU_SYNT=0, any state:
  - Next edge enters OFF and clears the phase counter, the watchdog and ERR_TOUT.
  - CH_ACT is kept.
- OFF: on an edge with PU_SYNT=1, go to CAL; phase counter loads TCAL_CYC; watchdog clears.
- CAL:
  - Watchdog increments every cycle.
  - Phase counter decrements only on cycles with CAL_SYNT=1.
  - If counter==1 and CAL_SYNT=1: go to SETTLE and load TSET_CYC.
  - Else if the watchdog reaches TOUT_CYC: go to ERROR and set ERR_TOUT.
  - If both conditions hit on the same edge, the SETTLE transition wins.
- SETTLE: decrement every cycle; at counter==1, go to READY.
- Nominal latency, with CAL_SYNT held high:
  - PU_SYNT sampled high at edge 0 means RDY_SYNT=1 after edge TCAL_CYC+TSET_CYC.
  - With defaults this is edge 60 (12 us).
- Each CAL cycle with CAL_SYNT=0 extends latency by exactly one cycle.
- READY:
  - CH_LOAD=1 latches CH_CODE into CH_ACT, goes to RELOCK and loads TRELOCK_CYC.
  - RDY_SYNT falls on that same edge.
- RELOCK:
  - Decrement every cycle; at counter==1, go to READY.
  - CH_LOAD during RELOCK re-latches CH_ACT and reloads TRELOCK_CYC (restart).
- CH_LOAD in OFF, CAL or SETTLE: CH_ACT updates; no state or counter change.
- ERROR: RDY_SYNT=0; held until PU_SYNT=0. CH_LOAD still updates CH_ACT.
- Watchdog saturates at TOUT_CYC. No counter ever wraps.
- Deassertion of RST_N must be synchronised by the integrator; the block does not resynchronise it.

Test Plan:
- Defaults, CAL_SYNT=1, PU_SYNT high at edge 0 -> STATE: CAL after edge 0, SETTLE after edge 50, READY after edge 60; RDY_SYNT rises exactly after edge 60; CAL_BUSY high for edges 0..49.
- CAL_SYNT low for 7 cycles mid-CAL -> RDY_SYNT rises after edge 67; no error.
- CAL_SYNT held 0 -> ERROR after 200 cycles in CAL; ERR_TOUT=1 and stays set; PU_SYNT pulsed low -> OFF and ERR_TOUT=0.
- In READY: CH_LOAD with CH_CODE=0x2A -> CH_ACT=0x2A and RDY_SYNT low; RDY_SYNT returns after 5 cycles. Second CH_LOAD (0x15) 3 cycles into RELOCK -> CH_ACT=0x15, READY 5 cycles after the second load.
- PU_SYNT dropped at cycle 30 of CAL -> OFF next edge; re-raised -> full 60-cycle sequence. RST_N asserted mid-SETTLE -> immediate OFF and CH_ACT=0 with no clock edge.
- Parameter set TCAL_CYC=1, TSET_CYC=1, TRELOCK_CYC=1 -> RDY_SYNT after edge 2; relock takes 1 cycle.
